// File: rtl/audio_mixer.sv
// Stereo PCM mixer: snapshots AY levels + beeper each DIVIDER clocks, mixes by mode,
// scales by master volume with a serial shift-add, and emits saturated signed 16-bit samples.
module audio_mixer #(
  parameter int unsigned DIVIDER = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  ch_a_i,
  input  logic [7:0]  ch_b_i,
  input  logic [7:0]  ch_c_i,
  input  logic        beep_i,
  input  logic [1:0]  mode_i,
  input  logic [3:0]  vol_i,
  output logic [15:0] left_o,
  output logic [15:0] right_o,
  output logic        sample_o
);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_SCALE, S_SAT, S_OUT} state_t;

  localparam logic [1:0] M_MONO = 2'b00;
  localparam logic [1:0] M_ABC  = 2'b01;
  localparam logic [1:0] M_ACB  = 2'b10;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [1:0]  r_step;
  logic [7:0]  r_a, r_b, r_c;
  logic        r_beep;
  logic [1:0]  r_mode;
  logic [3:0]  r_vol;
  logic [9:0]  r_sum_l, r_sum_r;
  logic [13:0] r_prod_l, r_prod_r;
  logic [15:0] r_sat_l, r_sat_r;

  logic        w_tick;
  logic [9:0]  w_add_l, w_add_r;
  logic [13:0] w_sh_l, w_sh_r;
  logic [16:0] w_res_l, w_res_r;

  assign w_tick = (r_cnt == 16'(DIVIDER - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else r_cnt <= r_cnt + 16'd1;
  end

  // Per-cycle contribution of the source selected by r_step (A, B, C, beep).
  always_comb begin
    w_add_l = '0;
    w_add_r = '0;
    case (r_step)
      2'd0: begin
        if (r_mode == M_MONO) begin
          w_add_l = {2'b00, r_a};
          w_add_r = {2'b00, r_a};
        end else if (r_mode == M_ABC || r_mode == M_ACB) begin
          w_add_l = {1'b0, r_a, 1'b0};
        end
      end
      2'd1: begin
        if (r_mode == M_MONO || r_mode == M_ABC) begin
          w_add_l = {2'b00, r_b};
          w_add_r = {2'b00, r_b};
        end else if (r_mode == M_ACB) begin
          w_add_r = {1'b0, r_b, 1'b0};
        end
      end
      2'd2: begin
        if (r_mode == M_MONO || r_mode == M_ACB) begin
          w_add_l = {2'b00, r_c};
          w_add_r = {2'b00, r_c};
        end else if (r_mode == M_ABC) begin
          w_add_r = {1'b0, r_c, 1'b0};
        end
      end
      default: begin
        if (r_beep && (r_mode != 2'b11)) begin
          w_add_l = 10'd64;
          w_add_r = 10'd64;
        end
      end
    endcase
  end

  assign w_sh_l  = {4'b0000, r_sum_l} << r_step;
  assign w_sh_r  = {4'b0000, r_sum_r} << r_step;
  assign w_res_l = {1'b0, r_prod_l, 2'b00} - 17'd16384;
  assign w_res_r = {1'b0, r_prod_r, 2'b00} - 17'd16384;

  // Result never drops below -16384, so only the positive ceiling needs clipping.
  function automatic logic [15:0] sat16(input logic [16:0] v);
    if (!v[16] && v[15]) return 16'h7FFF;
    return v[15:0];
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_beep   <= 1'b0;
      r_mode   <= '0;
      r_vol    <= '0;
      r_sum_l  <= '0;
      r_sum_r  <= '0;
      r_prod_l <= '0;
      r_prod_r <= '0;
      r_sat_l  <= '0;
      r_sat_r  <= '0;
      left_o   <= '0;
      right_o  <= '0;
      sample_o <= 1'b0;
    end else begin
      sample_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_a      <= ch_a_i;
            r_b      <= ch_b_i;
            r_c      <= ch_c_i;
            r_beep   <= beep_i;
            r_mode   <= mode_i;
            r_vol    <= vol_i;
            r_sum_l  <= '0;
            r_sum_r  <= '0;
            r_prod_l <= '0;
            r_prod_r <= '0;
            r_step   <= '0;
            r_state  <= S_ACC;
          end
        end
        S_ACC: begin
          r_sum_l <= r_sum_l + w_add_l;
          r_sum_r <= r_sum_r + w_add_r;
          r_step  <= r_step + 2'd1;
          if (r_step == 2'd3) r_state <= S_SCALE;
        end
        S_SCALE: begin
          if (r_vol[r_step]) begin
            r_prod_l <= r_prod_l + w_sh_l;
            r_prod_r <= r_prod_r + w_sh_r;
          end
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) r_state <= S_SAT;
        end
        S_SAT: begin
          r_sat_l <= sat16(w_res_l);
          r_sat_r <= sat16(w_res_r);
          r_state <= S_OUT;
        end
        S_OUT: begin
          left_o   <= r_sat_l;
          right_o  <= r_sat_r;
          sample_o <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// Randomized bench for audio_mixer: a per-tick arithmetic model predicts every sample,
// and every cycle the strobe and held outputs are compared against it.
module tb_audio_mixer;

  localparam int unsigned DIV = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  ch_a, ch_b, ch_c;
  logic        beep;
  logic [1:0]  mode;
  logic [3:0]  vol;
  logic [15:0] left_o, right_o;
  logic        sample_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  audio_mixer #(.DIVIDER(DIV)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .ch_a_i  (ch_a),
    .ch_b_i  (ch_b),
    .ch_c_i  (ch_c),
    .beep_i  (beep),
    .mode_i  (mode),
    .vol_i   (vol),
    .left_o  (left_o),
    .right_o (right_o),
    .sample_o(sample_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain arithmetic from the mixing rules.
  function automatic logic [31:0] model(input int a, input int b, input int c,
                                        input int bp, input int md, input int v);
    int sl, sr, rl, rr;
    case (md)
      0: begin sl = a + b + c + 64*bp; sr = sl; end
      1: begin sl = 2*a + b + 64*bp; sr = 2*c + b + 64*bp; end
      2: begin sl = 2*a + c + 64*bp; sr = 2*b + c + 64*bp; end
      default: begin sl = 0; sr = 0; end
    endcase
    rl = 4*sl*v - 16384;
    rr = 4*sr*v - 16384;
    if (rl > 32767) rl = 32767;
    if (rr > 32767) rr = 32767;
    return {rl[15:0], rr[15:0]};
  endfunction

  int unsigned  edge_n = 0;
  logic [31:0]  q[$];
  logic [31:0]  exp_lr = '0;

  always @(posedge clk) begin
    if (rst) begin
      edge_n = 0;
      q.delete();
      exp_lr = '0;
    end else begin
      edge_n++;
      if (edge_n % DIV == 0)
        q.push_back(model(ch_a, ch_b, ch_c, beep, mode, vol));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_sample", {31'd0, sample_o}, 32'd0);
      check("rst_lr", {left_o, right_o}, 32'd0);
    end else begin
      if (edge_n >= DIV + 10 && (edge_n - 10) % DIV == 0) begin
        check("pending", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) exp_lr = q.pop_front();
        check("strobe_hi", {31'd0, sample_o}, 32'd1);
      end else begin
        check("strobe_lo", {31'd0, sample_o}, 32'd0);
      end
      check("lr", {left_o, right_o}, exp_lr);
    end
  end

  // {a, b, c, beep, mode, vol}
  logic [30:0] dir [6] = '{
    {8'd100, 8'd0,   8'd0,   1'b0, 2'b01, 4'd8},
    {8'd10,  8'd10,  8'd10,  1'b0, 2'b00, 4'd1},
    {8'd255, 8'd255, 8'd255, 1'b1, 2'b01, 4'd15},
    {8'd77,  8'd200, 8'd3,   1'b1, 2'b11, 4'd9},
    {8'd200, 8'd100, 8'd50,  1'b1, 2'b10, 4'd0},
    {8'd0,   8'd50,  8'd0,   1'b0, 2'b10, 4'd1}
  };

  task automatic randomize_inputs();
    ch_a = 8'($urandom);
    ch_b = 8'($urandom);
    ch_c = 8'($urandom);
    beep = 1'($urandom);
    mode = 2'($urandom);
    vol  = 4'($urandom);
  endtask

  initial begin
    int unsigned tick_i;
    bit          did_rst;
    logic [30:0] v;
    tick_i  = 0;
    did_rst = 1'b0;
    rst = 1'b1;
    {ch_a, ch_b, ch_c, beep, mode, vol} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int cyc = 0; cyc < 900; cyc++) begin
      @(posedge clk);
      #1;
      if (!did_rst && edge_n >= 200 && edge_n % DIV == 6) begin
        did_rst = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_rst_lr", {left_o, right_o}, 32'd0);
        check("async_rst_strobe", {31'd0, sample_o}, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick_i = 0;
      end else if (edge_n % DIV == DIV - 1) begin
        if (tick_i < 6) begin
          v = dir[tick_i];
          {ch_a, ch_b, ch_c, beep, mode, vol} = v;
        end else begin
          randomize_inputs();
        end
        tick_i++;
      end else begin
        randomize_inputs();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_mixer.md
# audio_mixer

Stereo PCM mixer and sample-rate generator that feeds the I2S serialiser. It takes the three AY sound-chip channel levels and the beeper/tape bit, applies a stereo mode and a master volume, and saturates the result to signed 16-bit. It presents a new left/right sample pair once every DIVIDER clocks, with a one-cycle strobe. Between strobes the outputs are held stable, so the downstream I2S stage can resynchronise them safely.

## Interface
- DIVIDER, 1024: clocks per output sample; legal range 12..65535.
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  reset: one clock; asynchronous and active-high.
- ch_a_i  in  8  AY channel A level, unsigned.
- ch_b_i  in  8  AY channel B level, unsigned.
- ch_c_i  in  8  AY channel C level, unsigned.
- beep_i  in  1  beeper/tape bit; adds a constant 64 to both channels when high.
- mode_i  in  2  mixing mode: 00 mono, 01 ABC, 10 ACB, 11 mute.
- vol_i  in  4  master volume, 0..15; linear gain.
- left_o  out  16  left sample, signed two's complement.
- right_o  out  16  right sample, signed two's complement.
- sample_o  out  1  one-cycle pulse, high on the cycle the new left_o/right_o first appear.

## Operation
- **Divider**
  - 16-bit counter cnt runs 0..DIVIDER-1 and wraps to 0.
  - The wrap edge is the "tick".
- **FSM states and transitions**
  - IDLE -> ACC on tick.
  - ACC: 4 cycles, one source per cycle, order A, B, C, beep.
  - SCALE: 4 cycles, volume bits 0..3.
  - SAT: 1 cycle.
  - OUT: 1 cycle, then back to IDLE.
- **Snapshot:** on the tick edge, ch_a/b/c, beep, mode and vol are registered. Input changes after the tick do not affect the sample in flight.
- **Accumulation:** two 10-bit unsigned sums, sumL and sumR, cleared on the tick.
  - mono: sumL = sumR = A + B + C + 64·beep.
  - ABC: sumL = 2A + B + 64·beep; sumR = 2C + B + 64·beep.
  - ACB: sumL = 2A + C + 64·beep; sumR = 2B + C + 64·beep.
  - mute: both sums 0.
  - Maximum sum is 829, which fits in 10 bits.
- **Scale:** shift-add multiply, one adder per channel.
  - In cycle k, prod += sum << k if vol[k] is set.
  - prod is 14-bit unsigned, maximum 12435.
- **SAT:** r = 4·prod − 16384, computed at 17-bit signed.
  - If r > 32767 the result is 32767.
  - The lower bound is unreachable; the minimum result is −16384 (0xC000).
- **OUT:** left_o/right_o load the SAT results and sample_o = 1.
- **Reset (asserted at any time, including mid-computation)**
  - Effects: cnt = 0, state = IDLE, left_o = right_o = 0, sample_o = 0.
  - No partial sample is ever emitted.
- **Simultaneous events:** a tick can never coincide with a busy FSM (guaranteed by DIVIDER ≥ 12). A tick seen outside IDLE is ignored.

## Timing
- Edge numbering: the tick edge is edge 0.
- ACC runs on edges 1–4, SCALE on edges 5–8, SAT on edge 9.
- Edge 10: left_o, right_o and sample_o = 1 update together.
- Edge 11: sample_o returns to 0.
- Latency from input snapshot to output is 10 clocks.
- left_o/right_o are stable for exactly DIVIDER cycles between updates.
- After reset release:
  - First tick occurs at the DIVIDER-th rising edge.
  - First sample_o occurs 10 edges later.
  - Thereafter sample_o has a period of exactly DIVIDER.

## Test plan
- Reset, then DIVIDER=16, mode ABC, A=100, B=C=0, beep=0, vol=8 -> sample_o pulses every 16 cycles; left_o = 0xD900 (−9984), right_o = 0xC000.
- Mono, A=B=C=10, vol=1 -> left_o = right_o = 0xC078 (−16264).
- ABC, all channels 255, beep=1, vol=15 -> sum 829, prod 12435, saturation -> left_o = right_o = 0x7FFF.
- Mute or vol=0, with any channel values -> both outputs 0xC000. ACB with A=0, B=50, C=0, vol=1 -> left_o = 0xC000, right_o = 0xC190.
- Change inputs on edges 1–9 after a tick -> the sample emitted at edge 10 reflects only the values registered at the tick.
- Assert rst_i during SCALE -> outputs 0 and sample_o 0 immediately. No pulse until DIVIDER+10 edges after release.
